// File: rtl/multi_alarm_clock.sv
// Time-of-day clock in BCD with N independent alarms, each running its own
// idle/ringing/snoozed FSM, plus a registered HHMMSS display of the selected target.
module multi_alarm_clock #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned N_ALARMS       = 4,
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  localparam int unsigned SEL_W         = $clog2(N_ALARMS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adj_min,
  input  logic                adj_hour,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                snooze,
  input  logic                dismiss,
  input  logic                fmt12,
  output logic [23:0]         disp_bcd,
  output logic                pm,
  output logic [N_ALARMS-1:0] ringing,
  output logic                ring_any,
  output logic                sec_pulse
);
  localparam int unsigned PW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned SNZ_SEC = SNOOZE_MINUTES * 60;
  localparam int unsigned CNT_MAX = (RING_SECONDS > SNZ_SEC) ? RING_SECONDS : SNZ_SEC;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] RING_LD = CW'(RING_SECONDS);
  localparam logic [CW-1:0] SNZ_LD  = CW'(SNZ_SEC);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} alarm_st_e;

  // Increment a two-digit BCD value, wrapping to 00 after lim.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
  logic          tick, time_adj, tick_eff;

  logic [N_ALARMS-1:0][7:0] al_hh, al_mm;
  logic [N_ALARMS-1:0]      is_ring;

  logic [7:0] hsel, dh, dm, ds;
  logic [4:0] hbin, h12;
  logic       pm_d;

  assign tick      = (pre_q == PW'(CLK_FREQ - 1));
  assign time_adj  = (adj_min || adj_hour) && (sel == '0);
  assign tick_eff  = tick && !time_adj;
  assign sec_pulse = tick;
  assign ring_any  = |ringing;

  always_comb begin
    pre_d = (tick || time_adj) ? '0 : pre_q + PW'(1);
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    if (time_adj) begin
      if (adj_min) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        ss_d = 8'h00;
      end
      if (adj_hour) hh_d = bcd_inc(hh_q, 8'h23);
    end else if (tick) begin
      ss_d = bcd_inc(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
      end
    end
  end

  for (genvar k = 0; k < N_ALARMS; k++) begin : g_alarm
    alarm_st_e     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ahh_q, ahh_d, amm_q, amm_d;
    logic          hit, match;

    assign hit = (sel == SEL_W'(k + 1));
    // Only a real tick can land on the alarm time; adjusted time never matches.
    assign match = tick_eff && ({hh_d, mm_d, ss_d} == {ahh_q, amm_q, 8'h00});

    always_comb begin
      ahh_d = ahh_q;
      amm_d = amm_q;
      st_d  = st_q;
      cnt_d = cnt_q;
      if (hit && adj_min)  amm_d = bcd_inc(amm_q, 8'h59);
      if (hit && adj_hour) ahh_d = bcd_inc(ahh_q, 8'h23);
      if (!alarm_en[k] || (hit && (adj_min || adj_hour))) begin
        st_d  = StIdle;
        cnt_d = '0;
      end else begin
        case (st_q)
          StIdle: begin
            if (match) begin
              st_d  = StRing;
              cnt_d = RING_LD;
            end
          end
          StRing: begin
            if (dismiss) begin
              st_d  = StIdle;
              cnt_d = '0;
            end else if (snooze) begin
              st_d  = StSnooze;
              cnt_d = SNZ_LD;
            end else if (tick_eff) begin
              if (cnt_q <= CW'(1)) begin
                st_d  = StIdle;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end
          end
          StSnooze: begin
            if (dismiss) begin
              st_d  = StIdle;
              cnt_d = '0;
            end else if (tick_eff) begin
              if (cnt_q <= CW'(1)) begin
                st_d  = StRing;
                cnt_d = RING_LD;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end
          end
          default: begin
            st_d  = StIdle;
            cnt_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= StIdle;
        cnt_q <= '0;
        ahh_q <= '0;
        amm_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ahh_q <= ahh_d;
        amm_q <= amm_d;
      end
    end

    assign al_hh[k]   = ahh_q;
    assign al_mm[k]   = amm_q;
    assign is_ring[k] = (st_q == StRing);
  end

  // Out-of-range selects fall through to the time of day.
  always_comb begin
    hsel = hh_q;
    dm   = mm_q;
    ds   = ss_q;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        hsel = al_hh[k];
        dm   = al_mm[k];
        ds   = 8'h00;
      end
    end
    hbin = {1'b0, hsel[7:4]} * 5'd10 + {1'b0, hsel[3:0]};
    h12  = hbin - 5'd12;
    dh   = hsel;
    pm_d = 1'b0;
    if (fmt12) begin
      pm_d = (hbin >= 5'd12);
      if (hbin == 5'd0) begin
        dh = 8'h12;
      end else if (hbin > 5'd12) begin
        dh = (h12 >= 5'd10) ? {4'd1, h12[3:0] - 4'd10} : {4'd0, h12[3:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
      disp_bcd <= '0;
      pm       <= 1'b0;
      ringing  <= '0;
    end else begin
      pre_q    <= pre_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      disp_bcd <= {dh, dm, ds};
      pm       <= pm_d;
      ringing  <= is_ring;
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: a seconds-of-day reference model predicts
// every cycle's outputs, a monitor pops and compares them.
module tb_multi_alarm_clock;
  localparam int CLK_FREQ = 10;
  localparam int N_AL     = 2;
  localparam int RING_S   = 3;
  localparam int SNZ_M    = 1;
  localparam int M_IDLE   = 0;
  localparam int M_RING   = 1;
  localparam int M_SNZ    = 2;

  logic        clk = 1'b0;
  logic        rst_n, adj_min, adj_hour, snooze, dismiss, fmt12;
  logic [1:0]  sel, alarm_en;
  logic [23:0] disp_bcd;
  logic        pm, ring_any, sec_pulse;
  logic [1:0]  ringing;

  multi_alarm_clock #(
    .CLK_FREQ       (CLK_FREQ),
    .N_ALARMS       (N_AL),
    .RING_SECONDS   (RING_S),
    .SNOOZE_MINUTES (SNZ_M)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adj_min   (adj_min),
    .adj_hour  (adj_hour),
    .sel       (sel),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .fmt12     (fmt12),
    .disp_bcd  (disp_bcd),
    .pm        (pm),
    .ringing   (ringing),
    .ring_any  (ring_any),
    .sec_pulse (sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       adj_min;
    logic       adj_hour;
    logic [1:0] sel;
    logic [1:0] en;
    logic       snooze;
    logic       dismiss;
    logic       fmt12;
  } stim_t;

  typedef struct {
    logic [23:0] disp;
    logic        pm;
    logic [1:0]  ring;
    logic        sec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: time as seconds of day, alarms as minutes of day.
  int m_pre, m_t;
  int m_al[N_AL];
  int m_st[N_AL];
  int m_cnt[N_AL];

  logic [1:0] lv_en, lv_sel;
  logic       lv_fmt;

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic m_reset();
    m_pre = 0;
    m_t   = 0;
    for (int k = 0; k < N_AL; k++) begin
      m_al[k]  = 0;
      m_st[k]  = M_IDLE;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input stim_t s);
    int   h, mi, sc, tn;
    bit   tick, tadj, teff, hit, adjk, match;
    exp_t e;
    if (!s.rst_n) begin
      m_reset();
      e.disp = '0;
      e.pm   = 1'b0;
      e.ring = '0;
      e.sec  = 1'b0;
      exp_q.push_back(e);
      return;
    end
    tn = m_t;
    if (s.sel >= 2'd1 && int'(s.sel) <= N_AL) tn = m_al[int'(s.sel) - 1] * 60;
    h  = tn / 3600;
    mi = (tn / 60) % 60;
    sc = tn % 60;
    e.pm = 1'b0;
    if (s.fmt12) begin
      e.pm = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    e.disp = {bcd2(h), bcd2(mi), bcd2(sc)};
    for (int k = 0; k < N_AL; k++) e.ring[k] = (m_st[k] == M_RING);

    tick  = (m_pre == CLK_FREQ - 1);
    tadj  = (s.adj_min || s.adj_hour) && (s.sel == 2'd0);
    teff  = tick && !tadj;
    m_pre = (tick || tadj) ? 0 : m_pre + 1;
    if (tadj) begin
      h  = m_t / 3600;
      mi = (m_t / 60) % 60;
      sc = m_t % 60;
      if (s.adj_min) begin
        mi = (mi + 1) % 60;
        sc = 0;
      end
      if (s.adj_hour) h = (h + 1) % 24;
      m_t = h * 3600 + mi * 60 + sc;
    end else if (tick) begin
      m_t = (m_t + 1) % 86400;
    end

    for (int k = 0; k < N_AL; k++) begin
      hit   = (int'(s.sel) == k + 1);
      adjk  = hit && (s.adj_min || s.adj_hour);
      match = teff && (m_t == m_al[k] * 60);
      if (hit && s.adj_min)  m_al[k] = (m_al[k] / 60) * 60 + (m_al[k] % 60 + 1) % 60;
      if (hit && s.adj_hour) m_al[k] = ((m_al[k] / 60 + 1) % 24) * 60 + m_al[k] % 60;
      if (!s.en[k] || adjk) begin
        m_st[k]  = M_IDLE;
        m_cnt[k] = 0;
      end else if (m_st[k] == M_IDLE) begin
        if (match) begin
          m_st[k]  = M_RING;
          m_cnt[k] = RING_S;
        end
      end else if (m_st[k] == M_RING) begin
        if (s.dismiss) m_st[k] = M_IDLE;
        else if (s.snooze) begin
          m_st[k]  = M_SNZ;
          m_cnt[k] = SNZ_M * 60;
        end else if (teff) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_st[k] = M_IDLE;
        end
      end else begin
        if (s.dismiss) m_st[k] = M_IDLE;
        else if (teff) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) begin
            m_st[k]  = M_RING;
            m_cnt[k] = RING_S;
          end
        end
      end
    end
    e.sec = (m_pre == CLK_FREQ - 1);
    exp_q.push_back(e);
  endtask

  function automatic stim_t mk(input bit am, input bit ah, input bit sz, input bit dm);
    stim_t s;
    s.rst_n    = 1'b1;
    s.adj_min  = am;
    s.adj_hour = ah;
    s.sel      = lv_sel;
    s.en       = lv_en;
    s.snooze   = sz;
    s.dismiss  = dm;
    s.fmt12    = lv_fmt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst_n    = s.rst_n;
    adj_min  = s.adj_min;
    adj_hour = s.adj_hour;
    sel      = s.sel;
    alarm_en = s.en;
    snooze   = s.snooze;
    dismiss  = s.dismiss;
    fmt12    = s.fmt12;
    model_step(s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(mk(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic pulse(input bit am, input bit ah, input bit sz, input bit dm);
    drive(mk(am, ah, sz, dm));
  endtask

  task automatic do_reset(input int n);
    stim_t s;
    s = mk(1'b0, 1'b0, 1'b0, 1'b0);
    s.rst_n = 1'b0;
    for (int i = 0; i < n; i++) drive(s);
  endtask

  task automatic set_time(input int h, input int m);
    int ph, pmn;
    lv_sel = 2'd0;
    ph  = (h - m_t / 3600 + 24) % 24;
    pmn = (m - (m_t / 60) % 60 + 60) % 60;
    if (pmn == 0) pmn = 60;
    repeat (ph) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (pmn) pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    int ph, pmn;
    lv_sel = 2'(k + 1);
    ph  = (h - m_al[k] / 60 + 24) % 24;
    pmn = (m - m_al[k] % 60 + 60) % 60;
    repeat (ph) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (pmn) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    lv_sel = 2'd0;
  endtask

  task automatic run_until_ring(input int k);
    int g;
    g = 0;
    while (m_st[k] != M_RING && g < 1000) begin
      run(1);
      g++;
    end
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("disp_bcd", disp_bcd, e.disp);
        chk("pm", 24'(pm), 24'(e.pm));
        chk("ringing", 24'(ringing), 24'(e.ring));
        chk("ring_any", 24'(ring_any), 24'(|e.ring));
        chk("sec_pulse", 24'(sec_pulse), 24'(e.sec));
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    int a, g;
    rst_n = 1'b0; adj_min = 1'b0; adj_hour = 1'b0; sel = '0; alarm_en = '0;
    snooze = 1'b0; dismiss = 1'b0; fmt12 = 1'b0;
    lv_en = 2'b00; lv_sel = 2'd0; lv_fmt = 1'b0;
    m_reset();
    do_reset(3);
    run(25);

    // Midnight wrap
    set_time(23, 59);
    run(590);
    run(15);

    // Trigger and auto-stop
    set_alarm(0, 7, 0);
    lv_en = 2'b01;
    set_time(6, 59);
    run(600);
    run(45);

    // Snooze, re-ring, dismiss with no re-ring
    set_time(6, 59);
    run_until_ring(0);
    run(3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    run(5);
    run_until_ring(0);
    run(4);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    run(700);

    // Both alarms; snooze and dismiss together
    set_alarm(1, 7, 0);
    lv_en = 2'b11;
    set_time(6, 59);
    run_until_ring(0);
    run(2);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    run(60);

    // 12-hour display of time and alarm views
    lv_en  = 2'b00;
    lv_fmt = 1'b1;
    set_time(0, 30);
    run(5);
    set_time(13, 5);
    run(5);
    set_time(12, 0);
    run(3);
    for (int s = 1; s < 4; s++) begin
      lv_sel = 2'(s);
      run(3);
    end
    lv_sel = 2'd0;
    lv_fmt = 1'b0;
    run(3);

    // Adjust colliding with the tick onto an alarm time
    set_alarm(0, 10, 0);
    lv_en = 2'b01;
    set_time(10, 59);
    run(300);
    g = 0;
    while (m_pre != CLK_FREQ - 1 && g < 20) begin
      run(1);
      g++;
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    run(40);

    // Reset mid-ring, then mid-snooze
    set_time(9, 59);
    run_until_ring(0);
    run(2);
    do_reset(2);
    run(15);
    lv_en = 2'b01;
    set_alarm(0, 0, 1);
    set_time(0, 0);
    run_until_ring(0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    run(30);
    do_reset(1);
    run(25);

    // Randomised traffic with alarms armed just ahead of the current time
    a = (m_t / 60 + 1) % 1440;
    set_alarm(0, a / 60, a % 60);
    a = (a + 1) % 1440;
    set_alarm(1, a / 60, a % 60);
    lv_en = 2'b11;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) lv_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) lv_en = 2'($urandom);
      if ($urandom_range(0, 99) == 0) lv_fmt = ~lv_fmt;
      if ($urandom_range(0, 1499) == 0) do_reset(1);
      else pulse($urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
    end

    g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
